// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared keycodes and scheduler state encoding
package calc_pkg;

  localparam logic [4:0] KEY_CE  = 5'b00001;
  localparam logic [4:0] KEY_DEL = 5'b00010;
  localparam logic [4:0] KEY_CA  = 5'b00011;
  localparam logic [4:0] KEY_EQ  = 5'b00100;
  localparam logic [4:0] KEY_SQ  = 5'b01100;

  // Operator keys carry this 3-bit prefix; digit keys have the MSB set.
  localparam logic [2:0] OP_PREFIX    = 3'b010;
  localparam logic       DIGIT_PREFIX = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ISSUE = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - pending key queue with flush-and-load for clear-all
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  input  logic                         flush_load,
  input  logic [W-1:0]                 flush_data,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic w_push_ok;
  logic w_pop_ok;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd];

  // A push into a full queue is only taken when the head leaves in the same cycle.
  assign w_push_ok = push && (!full || pop);
  assign w_pop_ok  = pop && !empty;

  // Storage write: clear-all always lands in slot 0 so the pointers restart cleanly.
  always_ff @(posedge clock) begin
    if (flush_load) begin
      r_mem[0] <= flush_data;
    end else if (w_push_ok) begin
      r_mem[r_wr] <= push_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (flush_load) begin
      r_rd    <= '0;
      r_wr    <= AW'(1);
      r_count <= CW'(1);
    end else begin
      if (w_push_ok) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd <= r_rd + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/calc_key_scheduler.sv
// rtl/calc_key_scheduler.sv - paces queued keypad codes into the calculator core
module calc_key_scheduler
  import calc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       keyValid,
  input  logic [4:0]                 keyIn,
  input  logic                       coreBusy,
  output logic                       newkey,
  output logic [4:0]                 keycode,
  output logic [$clog2(DEPTH+1)-1:0] queueCount,
  output logic                       full,
  output logic                       empty,
  output logic                       dropped
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t        r_state;
  logic [GW-1:0] r_gap_cnt;

  logic       w_is_ca;
  logic       w_push;
  logic       w_flush;
  logic       w_pop;
  logic       w_drop;
  logic [4:0] w_head;

  assign w_is_ca = (keyIn == KEY_CA);
  assign w_flush = keyValid && w_is_ca;
  assign w_push  = keyValid && !w_is_ca;
  assign w_pop   = (r_state == ST_ISSUE);
  assign w_drop  = w_push && full && !w_pop;

  key_fifo #(
    .DEPTH (DEPTH),
    .W     (5)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (w_push),
    .push_data  (keyIn),
    .pop        (w_pop),
    .flush_load (w_flush),
    .flush_data (keyIn),
    .head       (w_head),
    .count      (queueCount),
    .full       (full),
    .empty      (empty)
  );

  // Issue FSM: the head is latched onto keycode and popped on the edge leaving ISSUE,
  // and the gap leaves at least GAP quiet cycles before the next pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
      newkey    <= 1'b0;
      keycode   <= 5'b0;
      dropped   <= 1'b0;
    end else begin
      newkey  <= 1'b0;
      dropped <= w_drop;
      case (r_state)
        ST_IDLE: begin
          if (!empty && !coreBusy) begin
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          newkey    <= 1'b1;
          keycode   <= w_head;
          r_state   <= ST_GAP;
          r_gap_cnt <= GW'(GAP - 1);
        end
        ST_GAP: begin
          if (r_gap_cnt <= GW'(1)) begin
            r_gap_cnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_key_scheduler.sv
// tb/tb_calc_key_scheduler.sv - randomized scoreboard bench for calc_key_scheduler
module tb_calc_key_scheduler;
  import calc_pkg::*;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clock = 1'b0;
  logic          reset;
  logic          keyValid;
  logic [4:0]    keyIn;
  logic          coreBusy;
  logic          newkey;
  logic [4:0]    keycode;
  logic [CW-1:0] queueCount;
  logic          full;
  logic          empty;
  logic          dropped;

  always #5 clock = ~clock;

  calc_key_scheduler #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clock      (clock),
    .reset      (reset),
    .keyValid   (keyValid),
    .keyIn      (keyIn),
    .coreBusy   (coreBusy),
    .newkey     (newkey),
    .keycode    (keycode),
    .queueCount (queueCount),
    .full       (full),
    .empty      (empty),
    .dropped    (dropped)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Inputs as seen by the DUT at the most recent rising edge.
  logic       s_kv  = 1'b0;
  logic [4:0] s_key = 5'b0;
  logic       s_rst = 1'b0;
  logic       s_bsy = 1'b0;
  logic       p_bsy = 1'b0;

  always @(posedge clock) begin
    cyc   <= cyc + 1;
    s_kv  <= keyValid;
    s_key <= keyIn;
    s_rst <= reset;
    s_bsy <= coreBusy;
    p_bsy <= s_bsy;
  end

  // Reference queue of pending keys and record of issue times.
  logic [4:0] mq[$];
  logic [4:0] last_kc    = 5'b0;
  int         issue_cyc[$];
  int         last_issue = -100;
  int         stall      = 0;
  logic       exp_drop;

  always @(negedge clock) begin
    if (!s_rst) begin
      mq.delete();
      last_kc    = 5'b0;
      last_issue = -100;
      stall      = 0;
      chk("rst_newkey",  newkey,     0);
      chk("rst_keycode", keycode,    0);
      chk("rst_empty",   empty,      1);
      chk("rst_count",   queueCount, 0);
      chk("rst_dropped", dropped,    0);
    end else begin
      exp_drop = 1'b0;
      if (newkey) begin
        issue_cyc.push_back(cyc);
        chk("issue_needs_core_ready", p_bsy, 0);
        chk("issue_spacing_min", ((cyc - last_issue) >= GAP + 1), 1);
        last_issue = cyc;
        stall      = 0;
        if (mq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_issue actual=%0h required=no_issue (cycle %0d)", keycode, cyc);
        end else begin
          chk("issue_order", keycode, mq[0]);
          last_kc = mq.pop_front();
        end
      end else begin
        chk("keycode_hold", keycode, last_kc);
        if (mq.size() > 0 && !s_bsy) stall++;
        else stall = 0;
        if (stall > GAP + 2) begin
          total++;
          bad++;
          $display("FAIL issue_stall actual=%0d idle_cycles required<=%0d (cycle %0d)", stall, GAP + 2, cyc);
          stall = 0;
        end
      end
      if (s_kv) begin
        if (s_key == KEY_CA) begin
          mq.delete();
          mq.push_back(s_key);
        end else if (mq.size() == DEPTH) begin
          exp_drop = 1'b1;
        end else begin
          mq.push_back(s_key);
        end
      end
      chk("dropped", dropped,    exp_drop);
      chk("count",   queueCount, mq.size());
      chk("full",    full,       (mq.size() == DEPTH));
      chk("empty",   empty,      (mq.size() == 0));
    end
  end

  task automatic drive(input logic kv, input logic [4:0] k);
    @(posedge clock);
    #1;
    keyValid = kv;
    keyIn    = k;
  endtask

  task automatic wait_issues(input int n, input int lim, input string name);
    int i;
    for (i = 0; i < lim && issue_cyc.size() < n; i++) begin
      @(posedge clock);
      #1;
    end
    if (issue_cyc.size() < n) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=%0d issues required=%0d", name, issue_cyc.size(), n);
    end
  endtask

  task automatic wait_drain(input string name);
    int quiet;
    quiet = 0;
    for (int i = 0; i < 300 && quiet < GAP + 4; i++) begin
      @(posedge clock);
      #1;
      if (mq.size() == 0 && !newkey) quiet++;
      else quiet = 0;
    end
    if (quiet < GAP + 4) begin
      total++;
      bad++;
      $display("FAIL %s_drain_timeout actual=%0d pending required=0", name, mq.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    int n0;
    reset    = 1'b0;
    keyValid = 1'b1;
    keyIn    = 5'b10101;
    coreBusy = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset    = 1'b1;
    keyValid = 1'b0;
    keyIn    = 5'b0;
    @(posedge clock);
    #1;
    chk("post_reset_empty", empty, 1);

    // Single key latency.
    n0 = issue_cyc.size();
    drive(1'b1, 5'b10101);
    c0 = cyc;
    drive(1'b0, 5'b0);
    wait_issues(n0 + 1, 20, "single");
    if (issue_cyc.size() > n0) chk("single_latency", issue_cyc[n0] - c0, 3);
    chk("single_keycode", keycode, 5'b10101);
    wait_drain("single");
    chk("single_count_zero", queueCount, 0);

    // Burst of three.
    n0 = issue_cyc.size();
    drive(1'b1, 5'b10001);
    c0 = cyc;
    drive(1'b1, 5'b01001);
    drive(1'b1, 5'b10010);
    drive(1'b0, 5'b0);
    wait_issues(n0 + 3, 40, "burst");
    if (issue_cyc.size() >= n0 + 3) begin
      chk("burst_first",   issue_cyc[n0] - c0, 3);
      chk("burst_space_1", issue_cyc[n0+1] - issue_cyc[n0], GAP + 1);
      chk("burst_space_2", issue_cyc[n0+2] - issue_cyc[n0+1], GAP + 1);
    end
    wait_drain("burst");

    // Overflow while the core is busy.
    coreBusy = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 5'(5'b10000 + i));
    drive(1'b0, 5'b0);
    chk("ovf_full",  full,       1);
    chk("ovf_count", queueCount, DEPTH);
    n0 = issue_cyc.size();
    coreBusy = 1'b0;
    wait_drain("ovf");
    chk("ovf_issued", issue_cyc.size() - n0, DEPTH);

    // Clear-all collapses the queue.
    coreBusy = 1'b1;
    drive(1'b1, 5'b10110);
    drive(1'b1, 5'b00100);
    drive(1'b1, 5'b11001);
    drive(1'b1, KEY_CA);
    drive(1'b0, 5'b0);
    chk("ca_count",   queueCount, 1);
    chk("ca_dropped", dropped,    0);
    n0 = issue_cyc.size();
    coreBusy = 1'b0;
    wait_drain("ca");
    chk("ca_issued_once", issue_cyc.size() - n0, 1);
    chk("ca_keycode",     keycode,              KEY_CA);

    // Push into a full queue on the same edge as the pop.
    coreBusy = 1'b1;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 5'(5'b11000 + i));
    drive(1'b0, 5'b0);
    coreBusy = 1'b0;
    drive(1'b1, 5'b11111);
    drive(1'b0, 5'b0);
    chk("simul_pop",     newkey,     1);
    chk("simul_count",   queueCount, DEPTH);
    chk("simul_dropped", dropped,    0);
    wait_drain("simul");

    // Enough traffic to wrap the pointers several times.
    n0 = issue_cyc.size();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(1'b1, 5'(5'b10000 | $urandom_range(0, 15)));
      drive(1'b0, 5'b0);
      drive(1'b0, 5'b0);
    end
    wait_drain("wrap");
    chk("wrap_issued", issue_cyc.size() - n0, 3 * DEPTH);

    // Reset during GAP with two keys pending.
    coreBusy = 1'b1;
    drive(1'b1, 5'b10011);
    drive(1'b1, 5'b10100);
    drive(1'b1, 5'b10111);
    drive(1'b0, 5'b0);
    coreBusy = 1'b0;
    for (int i = 0; i < 20 && !newkey; i++) begin
      @(posedge clock);
      #1;
    end
    chk("mid_gap_reached", newkey, 1);
    chk("mid_gap_pending", queueCount, 2);
    reset    = 1'b0;
    keyValid = 1'b1;
    keyIn    = 5'b11101;
    @(posedge clock);
    #1;
    reset    = 1'b1;
    keyValid = 1'b0;
    chk("rst_mid_newkey",  newkey,  0);
    chk("rst_mid_keycode", keycode, 0);
    chk("rst_mid_empty",   empty,   1);
    n0 = issue_cyc.size();
    repeat (15) @(posedge clock);
    #1;
    chk("rst_mid_no_issue", issue_cyc.size() - n0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      #1;
      keyValid = ($urandom_range(0, 2) == 0);
      keyIn    = ($urandom_range(0, 11) == 0) ? KEY_CA : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) coreBusy = ~coreBusy;
      reset    = ($urandom_range(0, 99) != 0);
    end
    @(posedge clock);
    #1;
    keyValid = 1'b0;
    reset    = 1'b1;
    coreBusy = 1'b0;
    wait_drain("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calc_key_scheduler.md
CALC_KEY_SCHEDULER -- requirements
Module: calc_key_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, key queue entries (power of two, >=2).
REQ-002 Parameter GAP, default 2, minimum idle cycles between consecutive newkey pulses (>=1).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-005 keyValid  input  1  one-cycle pulse from keypad interface; keyIn is valid in that cycle.
REQ-006 keyIn  input  5  keycode of the pressed key.
REQ-007 coreBusy  input  1  high while the calculator core cannot accept a key; blocks issue.
REQ-008 newkey  output  1  registered one-cycle pulse to the core; keycode valid in that cycle.
REQ-009 keycode  output  5  registered code of the last issued key; held between issues.
REQ-010 queueCount  output  clog2(DEPTH+1)  number of pending keys.
REQ-011 full  output  1  queueCount == DEPTH.
REQ-012 empty  output  1  queueCount == 0.
REQ-013 dropped  output  1  registered one-cycle pulse when a key is discarded due to overflow.

Function
REQ-014 Queue is FIFO; keys are issued in arrival order, except as modified by REQ-020.
REQ-015 FSM states: IDLE, ISSUE, GAP.
REQ-016 IDLE: if queue non-empty and coreBusy low at the edge, go to ISSUE. Otherwise stay in IDLE.
REQ-017 ISSUE (one cycle): newkey=1; keycode=head entry; head popped at the same edge; go to GAP; load gap counter with GAP-1.
REQ-018 GAP: newkey=0; counter decrements each cycle; at 0 go to IDLE. coreBusy is ignored in GAP.
REQ-019 Latency: with queue empty, state IDLE and coreBusy low, newkey is high in the cycle two rising edges after keyValid is sampled. Back-to-back queued keys are issued every GAP+1 cycles.
REQ-020 Clear-all key (5'b00011) on keyValid: all pending entries are discarded and clear-all becomes the sole entry. This applies whether or not the queue is full, and dropped is not pulsed.
REQ-021 Any other key arriving when full with no pop in that cycle: the key is discarded and dropped pulses the next cycle. The queue is unchanged.
REQ-022 Simultaneous push and pop when full: the push is accepted and queueCount is unchanged.
REQ-023 Simultaneous clear-all push and ISSUE pop: the popped key is still issued, and the queue afterwards holds only clear-all (queueCount=1).
REQ-024 Read and write pointers wrap modulo DEPTH. queueCount never exceeds DEPTH and never underflows.
REQ-025 coreBusy rising while in ISSUE does not cancel the pulse already being driven.

Reset
REQ-026 On reset low at the edge: state=IDLE, queue emptied (pointers 0, queueCount=0), newkey=0, keycode=5'b0, dropped=0, gap counter=0.
REQ-027 A reset asserted mid-GAP or mid-ISSUE aborts the operation. Pending keys are lost, and no newkey is issued in the cycle after reset.
REQ-028 keyValid is ignored in any cycle where reset is low.

Structure
REQ-029 Shared package calc_pkg SHALL hold: keycode constants KEY_CE=5'b00001, KEY_DEL=5'b00010, KEY_CA=5'b00011, KEY_EQ=5'b00100, KEY_SQ=5'b01100; operator prefix 3'b010; digit prefix 1'b1; and the FSM state typedef.
REQ-030 The queue storage, pointers and count SHALL be a sub-module key_fifo with push, pop, flush_load, and full/empty/count outputs. FSM and gap counter reside in calc_key_scheduler.

Verification
REQ-031 Single key: reset released, keyValid with keyIn=5'b10101 -> newkey high exactly 2 edges later, keycode=5'b10101, queueCount returns to 0.
REQ-032 Burst: keys 5'b10001, 5'b01001, 5'b10010 on consecutive cycles, GAP=2 -> three newkey pulses spaced 3 cycles apart, in that order.
REQ-033 Overflow: coreBusy=1, push 5 digit keys with DEPTH=4 -> full=1, dropped pulses once for the 5th key; release coreBusy -> first 4 keys issued in order.
REQ-034 Clear-all: coreBusy=1, queue holds 3 keys, push 5'b00011 -> queueCount=1, no dropped; release coreBusy -> only keycode 5'b00011 issued.
REQ-035 Wrap/simultaneity: with the queue full, push a digit in the same cycle as an ISSUE pop -> accepted and queueCount stays 4; run 3*DEPTH keys through the queue -> order preserved across pointer wrap.
REQ-036 Reset mid-operation: reset low during GAP with 2 keys pending -> next cycle newkey=0, keycode=0, empty=1; no key is issued after reset is released.
